warp_scoreboard: RTL and testbench
==================================

# warp_scoreboard

Parametrised per-warp scoreboard that sits between the warp scheduler and the LSU/writeback path in the compute unit. For every warp it tracks pending destination registers, a bounded count of outstanding writes, and the busy-thread mask. It answers the scheduler's issue request combinationally with a single ready bit that covers RAW, WAW and outstanding-capacity hazards. State updates on accepted issue and on writeback completion.

## Interface
Parameters:
- NUM_WARPS, 4, warps tracked (power of two, ≥2)
- THREADS_PER_WARP, 8, thread-mask width per warp
- NUM_REGS, 16, architectural registers per warp (power of two)
- MAX_PENDING, 4, outstanding register writes allowed per warp (≥1)

Ports (WW = clog2(NUM_WARPS), RW = clog2(NUM_REGS)):
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- issue_valid  in  1  scheduler presents an instruction
- issue_warp  in  WW  warp of the instruction
- issue_rd, issue_rs1, issue_rs2  in  RW each  destination and sources
- issue_wr_en  in  1  instruction writes issue_rd
- issue_mask  in  THREADS_PER_WARP  active threads
- issue_ready  out  1  no hazard; issue accepted when issue_valid & issue_ready
- wb_valid  in  1  LSU/ALU completion
- wb_warp  in  WW, wb_rd  in  RW, wb_mask  in  THREADS_PER_WARP  completion target
- busy_threads  out  NUM_WARPS*THREADS_PER_WARP  warp w occupies bits [w*TPW +: TPW]
- warp_pending  out  NUM_WARPS  bit w = warp w outstanding count nonzero
- err  out  1  sticky protocol error

## Operation
- Per warp: pend[NUM_REGS] bitmap, cnt (0..MAX_PENDING) counter, busy[THREADS_PER_WARP] mask.
- Hazard for issue_warp w: pend[w][rs1] | pend[w][rs2] | (issue_wr_en & pend[w][rd]) | (issue_wr_en & cnt[w]==MAX_PENDING).
- issue_ready = ~hazard. It does not depend on issue_valid.
- Accepted issue: busy[w] |= issue_mask. If issue_wr_en, also set pend[w][rd] and cnt[w] += 1.
- wb_valid: clear pend[wb_warp][wb_rd], busy[wb_warp] &= ~wb_mask, cnt[wb_warp] -= 1.
- Simultaneous issue and wb, same warp: count is unchanged. Same register: pend ends set (set wins). Overlapping thread bits end set.
- Error: wb_valid with pend[wb_warp][wb_rd]==0 or cnt[wb_warp]==0 sets err. The counter never underflows and holds at 0. The clears still apply. err clears only on reset.
- Counter never exceeds MAX_PENDING, because issue is blocked at full.

## Timing
- issue_ready is combinational from the registered state and the issue_* inputs, with zero-cycle latency.
- All state updates on the rising edge after acceptance or wb. The effect is visible on issue_ready and outputs the next cycle.
- Reset is asynchronous. On reset, pend, cnt, busy and err all go to 0. busy_threads = 0, warp_pending = 0, err = 0, and issue_ready = 1.
- Reset asserted mid-operation discards all in-flight tracking immediately. Any wb arriving after reset is flagged in err.

## Configuration
- SCOREBOARD_WB_BYPASS_EN defined: a wb in the current cycle to issue_warp is treated as already retired for the hazard check.
  - pend[w][wb_rd] is masked out of the check.
  - cnt is evaluated as cnt-1 for the full check.
  - An instruction waiting on that register issues in the same cycle as the wb.
- Undefined: the hazard check uses registered state only. The dependent instruction issues one cycle after the wb.

## Structure
- Package sb_pkg holds:
  - the WW, RW and count-width localparams
  - a per-warp entry struct typedef {pend, cnt, busy}
  - a hazard-cause enum (NONE, RAW, WAW, FULL) for debug
- Sub-module sb_warp_entry is instantiated NUM_WARPS times via generate. Each instance holds one warp's state, set/clear logic and error detect.
- The top level decodes issue_warp/wb_warp, muxes the hazard check and ORs the per-entry errors.

## Test plan
- Reset, then issue warp 1 with rd=3, mask=0xFF, wr_en=1:
  - next cycle: busy_threads[15:8]=0xFF, warp_pending=4'b0010
  - an issue with rs1=3 on warp 1 gives issue_ready=0
  - the same issue on warp 2 gives issue_ready=1
- Issue 4 writes (rd 0..3) on warp 0. A 5th write (rd=5) gives issue_ready=0. A wb on rd=0 makes it ready the next cycle.
- Issue rd=7 on warp 2 while rd=7 is pending:
  - WAW gives issue_ready=0
  - a non-writing issue reading rd=8 gives issue_ready=1
- wb warp 3 rd=2 and an issue warp 3 rs1=2 in the same cycle:
  - with SCOREBOARD_WB_BYPASS_EN: issue_ready=1 that cycle
  - without: 0, then 1 the next cycle
- wb to warp 0 rd=9 with nothing pending: err=1 and stays 1, cnt stays 0. Asserting reset mid-sequence clears err and all outputs asynchronously.

Source files
------------

// File: rtl/sb_pkg.sv
// sb_pkg: shared widths, per-warp entry layout and hazard-cause encoding for warp_scoreboard.
package sb_pkg;
   localparam int DEF_NUM_WARPS        = 4;
   localparam int DEF_THREADS_PER_WARP = 8;
   localparam int DEF_NUM_REGS         = 16;
   localparam int DEF_MAX_PENDING      = 4;
   localparam int WW = $clog2(DEF_NUM_WARPS);
   localparam int RW = $clog2(DEF_NUM_REGS);
   localparam int CW = $clog2(DEF_MAX_PENDING + 1);

   typedef struct packed {
      logic [DEF_NUM_REGS-1:0]         pend;
      logic [CW-1:0]                   cnt;
      logic [DEF_THREADS_PER_WARP-1:0] busy;
   } sb_entry_t;

   typedef enum logic [1:0] {HZ_NONE, HZ_RAW, HZ_WAW, HZ_FULL} hz_cause_e;

   // Counter must hold 0..max_pending inclusive.
   function automatic int cnt_width(input int max_pending);
      return $clog2(max_pending + 1);
   endfunction
endpackage

// File: rtl/sb_warp_entry.sv
// sb_warp_entry: one warp's pending-register bitmap, outstanding-write counter,
// busy-thread mask and sticky protocol-error flag.
module sb_warp_entry
   import sb_pkg::*;
#(
   parameter int TPW = 8,
   parameter int NR  = 16,
   parameter int MP  = 4,
   localparam int RWL = $clog2(NR),
   localparam int CWL = cnt_width(MP)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_iss,
   input  logic            i_wr_en,
   input  logic [RWL-1:0]  i_rd,
   input  logic [TPW-1:0]  i_mask,
   input  logic            i_wb,
   input  logic [RWL-1:0]  i_wb_rd,
   input  logic [TPW-1:0]  i_wb_mask,
   output logic [NR-1:0]   o_pend,
   output logic [CWL-1:0]  o_cnt,
   output logic [TPW-1:0]  o_busy,
   output logic            o_err
);
   logic [NR-1:0]  r_pend;
   logic [CWL-1:0] r_cnt;
   logic [TPW-1:0] r_busy;
   logic           r_err;
   logic           w_inc;
   logic           w_bad;
   logic [NR-1:0]  w_set;
   logic [NR-1:0]  w_clr;

   assign w_inc = i_iss & i_wr_en;
   assign w_set = {NR{w_inc}} & (NR'(1) << i_rd);
   assign w_clr = {NR{i_wb}} & (NR'(1) << i_wb_rd);
   assign w_bad = i_wb & (~r_pend[i_wb_rd] | (r_cnt == '0));

   // Set is applied after clear so a same-register issue/wb leaves it pending.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_pend <= '0;
         r_cnt  <= '0;
         r_busy <= '0;
         r_err  <= 1'b0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_set;
         r_busy <= (r_busy & ~({TPW{i_wb}} & i_wb_mask)) | ({TPW{i_iss}} & i_mask);
         r_cnt  <= (w_inc & ~i_wb) ? r_cnt + CWL'(1) :
                   (i_wb & ~w_inc & (r_cnt != '0)) ? r_cnt - CWL'(1) : r_cnt;
         r_err  <= r_err | w_bad;
      end

   assign o_pend = r_pend;
   assign o_cnt  = r_cnt;
   assign o_busy = r_busy;
   assign o_err  = r_err;
endmodule

// File: rtl/warp_scoreboard.sv
// warp_scoreboard: per-warp RAW/WAW/capacity hazard tracking for the warp scheduler.
// SCOREBOARD_WB_BYPASS_EN: a same-cycle writeback to issue_warp counts as already retired.
module warp_scoreboard
   import sb_pkg::*;
#(
   parameter int NUM_WARPS        = DEF_NUM_WARPS,
   parameter int THREADS_PER_WARP = DEF_THREADS_PER_WARP,
   parameter int NUM_REGS         = DEF_NUM_REGS,
   parameter int MAX_PENDING      = DEF_MAX_PENDING,
   localparam int WWL = $clog2(NUM_WARPS),
   localparam int RWL = $clog2(NUM_REGS),
   localparam int CWL = cnt_width(MAX_PENDING)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  issue_valid,
   input  logic [WWL-1:0]                        issue_warp,
   input  logic [RWL-1:0]                        issue_rd,
   input  logic [RWL-1:0]                        issue_rs1,
   input  logic [RWL-1:0]                        issue_rs2,
   input  logic                                  issue_wr_en,
   input  logic [THREADS_PER_WARP-1:0]           issue_mask,
   output logic                                  issue_ready,
   input  logic                                  wb_valid,
   input  logic [WWL-1:0]                        wb_warp,
   input  logic [RWL-1:0]                        wb_rd,
   input  logic [THREADS_PER_WARP-1:0]           wb_mask,
   output logic [NUM_WARPS*THREADS_PER_WARP-1:0] busy_threads,
   output logic [NUM_WARPS-1:0]                  warp_pending,
   output logic                                  err
);
   logic [NUM_REGS-1:0] w_pend [NUM_WARPS];
   logic [CWL-1:0]      w_cnt  [NUM_WARPS];
   logic [NUM_WARPS-1:0] w_err;
   logic [NUM_REGS-1:0] w_chk;
   logic                w_byp;
   logic                w_full;
   logic                w_acc;
   hz_cause_e           w_cause;

`ifdef SCOREBOARD_WB_BYPASS_EN
   assign w_byp = wb_valid & (wb_warp == issue_warp);
`else
   assign w_byp = 1'b0;
`endif

   // A bypassed wb frees its register and one slot, so full only blocks without it.
   assign w_chk  = w_pend[issue_warp] & ~({NUM_REGS{w_byp}} & (NUM_REGS'(1) << wb_rd));
   assign w_full = (w_cnt[issue_warp] == CWL'(MAX_PENDING)) & ~w_byp;
   assign w_cause = (w_chk[issue_rs1] | w_chk[issue_rs2]) ? HZ_RAW :
                    (issue_wr_en & w_chk[issue_rd])       ? HZ_WAW :
                    (issue_wr_en & w_full)                ? HZ_FULL : HZ_NONE;
   assign issue_ready = (w_cause == HZ_NONE);
   assign w_acc = issue_valid & issue_ready;
   assign err = |w_err;

   for (genvar i = 0; i < NUM_WARPS; i++) begin : g_warp
      sb_warp_entry #(
         .TPW (THREADS_PER_WARP),
         .NR  (NUM_REGS),
         .MP  (MAX_PENDING)
      ) u_entry (
         .clk       (clk),
         .reset     (reset),
         .i_iss     (w_acc & (issue_warp == WWL'(i))),
         .i_wr_en   (issue_wr_en),
         .i_rd      (issue_rd),
         .i_mask    (issue_mask),
         .i_wb      (wb_valid & (wb_warp == WWL'(i))),
         .i_wb_rd   (wb_rd),
         .i_wb_mask (wb_mask),
         .o_pend    (w_pend[i]),
         .o_cnt     (w_cnt[i]),
         .o_busy    (busy_threads[i*THREADS_PER_WARP +: THREADS_PER_WARP]),
         .o_err     (w_err[i])
      );
      assign warp_pending[i] = |w_cnt[i];
   end
endmodule

// File: tb/tb_warp_scoreboard.sv
// tb_warp_scoreboard: directed scoreboard bench for warp_scoreboard (default 4 warps x 8 threads x 16 regs, depth 4).
module tb_warp_scoreboard;
   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [1:0]  issue_warp;
   logic [3:0]  issue_rd, issue_rs1, issue_rs2;
   logic        issue_wr_en;
   logic [7:0]  issue_mask;
   logic        issue_ready;
   logic        wb_valid;
   logic [1:0]  wb_warp;
   logic [3:0]  wb_rd;
   logic [7:0]  wb_mask;
   logic [31:0] busy_threads;
   logic [3:0]  warp_pending;
   logic        err;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;
   exp_t q[$];
   int tests = 0;
   int fails = 0;

   warp_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .issue_warp   (issue_warp),
      .issue_rd     (issue_rd),
      .issue_rs1    (issue_rs1),
      .issue_rs2    (issue_rs2),
      .issue_wr_en  (issue_wr_en),
      .issue_mask   (issue_mask),
      .issue_ready  (issue_ready),
      .wb_valid     (wb_valid),
      .wb_warp      (wb_warp),
      .wb_rd        (wb_rd),
      .wb_mask      (wb_mask),
      .busy_threads (busy_threads),
      .warp_pending (warp_pending),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic expect_val(input string tag, input logic [63:0] v);
      q.push_back('{tag, v});
   endtask

   task automatic chk(input logic [63:0] obs);
      exp_t e;
      tests++;
      if (q.size() == 0) begin
         fails++;
         $error("FAIL scoreboard_empty: observed %0h required nothing pending", obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.val)
         else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic iss(input logic v, input logic [1:0] w, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic wr, input logic [7:0] m);
      issue_valid = v; issue_warp = w; issue_rd = rd; issue_rs1 = rs1;
      issue_rs2 = rs2; issue_wr_en = wr; issue_mask = m;
   endtask

   task automatic wb(input logic v, input logic [1:0] w, input logic [3:0] rd, input logic [7:0] m);
      wb_valid = v; wb_warp = w; wb_rd = rd; wb_mask = m;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic byp;
`ifdef SCOREBOARD_WB_BYPASS_EN
      byp = 1'b1;
`else
      byp = 1'b0;
`endif
      reset = 1'b1;
      iss(0, 0, 0, 0, 0, 0, 8'h00);
      wb(0, 0, 0, 8'h00);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      expect_val("rst_ready", 1);  chk(issue_ready);
      expect_val("rst_busy", 0);   chk(busy_threads);
      expect_val("rst_pending", 0); chk(warp_pending);
      expect_val("rst_err", 0);    chk(err);

      // warp 1 writes r3 with all threads
      iss(1, 1, 3, 0, 0, 1, 8'hFF);
      expect_val("w1_issue_ready", 1); #1 chk(issue_ready);
      tick();
      iss(0, 1, 0, 3, 0, 0, 8'hFF);
      expect_val("w1_busy", 64'h0000FF00); chk(busy_threads);
      expect_val("w1_pending", 4'b0010);   chk(warp_pending);
      expect_val("w1_raw", 0); #1 chk(issue_ready);
      iss(0, 2, 0, 3, 0, 0, 8'hFF);
      expect_val("w2_no_raw", 1); #1 chk(issue_ready);

      // fill warp 0 to capacity
      for (int k = 0; k < 4; k++) begin
         iss(1, 0, 4'(k), 15, 15, 1, 8'h01);
         tick();
      end
      iss(0, 0, 5, 15, 15, 1, 8'h01);
      expect_val("w0_pending", 4'b0011); chk(warp_pending);
      expect_val("w0_full", 0); #1 chk(issue_ready);
      iss(0, 0, 5, 15, 15, 0, 8'h01);
      expect_val("w0_full_nowrite", 1); #1 chk(issue_ready);
      iss(0, 0, 5, 15, 15, 1, 8'h01);
      wb(1, 0, 0, 8'h01);
      expect_val("w0_full_wb_same", {63'b0, byp}); #1 chk(issue_ready);
      tick();
      wb(0, 0, 0, 8'h00);
      expect_val("w0_full_wb_next", 1); #1 chk(issue_ready);

      // warp 2: WAW / RAW / simultaneous issue+wb keeps count
      iss(1, 2, 7, 0, 0, 1, 8'h3C);
      tick();
      iss(0, 2, 7, 0, 0, 1, 8'h3C);
      expect_val("w2_waw", 0); #1 chk(issue_ready);
      iss(0, 2, 0, 8, 8, 0, 8'h3C);
      expect_val("w2_read_r8", 1); #1 chk(issue_ready);
      iss(0, 2, 0, 0, 7, 0, 8'h3C);
      expect_val("w2_raw_rs2", 0); #1 chk(issue_ready);
      iss(1, 2, 9, 0, 0, 1, 8'h3C);
      wb(1, 2, 7, 8'h00);
      expect_val("w2_issue_with_wb", 1); #1 chk(issue_ready);
      tick();
      wb(0, 0, 0, 8'h00);
      iss(0, 2, 0, 9, 9, 0, 8'h3C);
      expect_val("w2_cnt_kept", 4'b0111); chk(warp_pending);
      expect_val("w2_new_pend", 0); #1 chk(issue_ready);
      iss(0, 2, 0, 7, 7, 0, 8'h3C);
      expect_val("w2_old_cleared", 1); #1 chk(issue_ready);

      // warp 3: dependent issue in the same cycle as its writeback
      iss(1, 3, 2, 0, 0, 1, 8'h0F);
      tick();
      iss(1, 3, 0, 2, 0, 0, 8'hF0);
      wb(1, 3, 2, 8'h0F);
      expect_val("w3_bypass_same", {63'b0, byp}); #1 chk(issue_ready);
      tick();
      wb(0, 0, 0, 8'h00);
      expect_val("w3_after_wb", 1); #1 chk(issue_ready);
      tick();
      iss(0, 0, 0, 0, 0, 0, 8'h00);
      expect_val("all_busy", 64'hF03CFF00); chk(busy_threads);
      expect_val("all_pending", 4'b0111);   chk(warp_pending);
      expect_val("no_err", 0);              chk(err);

      // asynchronous reset mid-operation
      #2 reset = 1'b1;
      #1;
      expect_val("async_busy", 0);    chk(busy_threads);
      expect_val("async_pending", 0); chk(warp_pending);
      expect_val("async_ready", 1);   chk(issue_ready);
      expect_val("async_err", 0);     chk(err);
      @(negedge clk);
      reset = 1'b0;

      // stray writeback flags err, counter holds at 0
      wb(1, 0, 9, 8'h00);
      tick();
      wb(0, 0, 0, 8'h00);
      expect_val("err_set", 1);          chk(err);
      expect_val("err_cnt_zero", 0);     chk(warp_pending);
      tick();
      tick();
      expect_val("err_sticky", 1);       chk(err);
      iss(0, 0, 9, 9, 9, 1, 8'h01);
      expect_val("err_ready", 1); #1 chk(issue_ready);
      #1 reset = 1'b1;
      #1;
      expect_val("err_async_clear", 0); chk(err);
      @(negedge clk);
      reset = 1'b0;

      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_leftover: observed %0d entries required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
